// File: rtl/sar_search_controller_if.sv
// Handshake/bus bundle between the SAR search controller and its comparator/requester side.
interface sar_search_controller_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             lt;
  logic             gt;
  logic             eq;
  logic [WIDTH-1:0] guess;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             err;

  modport master (
    input  start, lt, gt, eq,
    output guess, busy, done, result, err
  );

  modport slave (
    output start, lt, gt, eq,
    input  guess, busy, done, result, err
  );
endinterface

// File: rtl/sar_search_controller.sv
// MSB-first successive-approximation search of a hidden operand using external lt/gt/eq flags.
module sar_search_controller #(
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  sar_search_controller_if.master bus
);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE, TRIAL} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] guess_q, guess_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             flags_ok;
  logic             last;
  logic             finish;
  logic [WIDTH-1:0] bit_m;

  // A lone flag is required; any other combination is a comparator fault,
  // which overrides the eq > gt > lt priority.
  assign flags_ok = $onehot({bus.lt, bus.gt, bus.eq});
  assign last     = (idx_q == '0);
  assign finish   = !flags_ok || bus.eq || last;
  assign bit_m    = WIDTH'(1) << idx_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      guess_q  <= '0;
      idx_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      guess_q  <= guess_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = TRIAL;
      TRIAL:   if (finish)    state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_comb begin
    guess_d  = guess_q;
    idx_d    = idx_q;
    result_d = result_q;
    done_d   = 1'b0;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          guess_d            = '0;
          guess_d[WIDTH-1]   = 1'b1;
          idx_d              = IW'(WIDTH-1);
          err_d              = 1'b0;
        end
      end
      TRIAL: begin
        if (!flags_ok) begin
          result_d = guess_q;
          err_d    = 1'b1;
          done_d   = 1'b1;
        end else if (bus.eq) begin
          result_d = guess_q;
          done_d   = 1'b1;
        end else if (last) begin
          // Only hidden==0 can legitimately run off the LSB with gt.
          result_d = bus.gt ? (guess_q & ~WIDTH'(1)) : guess_q;
          err_d    = !bus.gt;
          done_d   = 1'b1;
        end else begin
          guess_d = (bus.gt ? (guess_q & ~bit_m) : guess_q) | (bit_m >> 1);
          idx_d   = idx_q - IW'(1);
        end
      end
      default: ;
    endcase
  end

  assign bus.guess  = guess_q;
  assign bus.busy   = (state_q == TRIAL);
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.err    = err_q;
endmodule

// File: tb/tb_sar_search_controller.sv
// Directed bench: behavioural comparator around the SAR controller, with fault and reset injection.
module tb_sar_search_controller;
  localparam int WIDTH = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] hid = 8'h00;
  logic       fault = 1'b0;
  int         n_chk = 0;
  int         n_fail = 0;

  sar_search_controller_if #(.WIDTH(WIDTH)) bus();

  sar_search_controller #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign bus.lt = !fault && (bus.guess <  hid);
  assign bus.gt = !fault && (bus.guess >  hid);
  assign bus.eq = !fault && (bus.guess == hid);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Called #1 after an edge; accepts a search on the next edge.
  task automatic launch(input logic [7:0] h);
    hid       = h;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("launch_busy",  bus.busy,  1);
    chk("launch_guess", bus.guess, 32'h80);
    chk("launch_done",  bus.done,  0);
    chk("launch_err",   bus.err,   0);
  endtask

  task automatic finish(input string tag, input logic [7:0] exp_res, input logic exp_err,
                        input int exp_trials, input int fault_at, input bit pulse_busy);
    int  k = 0;
    int  trials = 0;
    int  busy_drop = 0;
    bit  got = 1'b0;
    while (!got && k < WIDTH + 2) begin
      k++;
      fault     = (k == fault_at);
      bus.start = pulse_busy && (k == 2 || k == 3);
      @(posedge clk); #1;
      bus.start = 1'b0;
      fault     = 1'b0;
      if (bus.done) begin
        got    = 1'b1;
        trials = k;
      end else if (!bus.busy) begin
        busy_drop++;
      end
    end
    chk({tag, "_done_seen"}, got, 1);
    chk({tag, "_trials"},    trials, exp_trials);
    chk({tag, "_result"},    bus.result, exp_res);
    chk({tag, "_err"},       bus.err, exp_err);
    chk({tag, "_busy_off"},  bus.busy, 0);
    chk({tag, "_busy_held"}, busy_drop, 0);
  endtask

  function automatic int sweep_trials(input logic [7:0] h);
    int t = WIDTH;
    for (int b = WIDTH - 1; b >= 0; b--)
      if (h[b]) t = WIDTH - b;
    return t;
  endfunction

  initial begin
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_guess",  bus.guess,  0);
    chk("rst_busy",   bus.busy,   0);
    chk("rst_done",   bus.done,   0);
    chk("rst_result", bus.result, 0);
    chk("rst_err",    bus.err,    0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_hold_busy", bus.busy, 0);

    launch(8'h80); finish("h80", 8'h80, 1'b0, 1, 0, 1'b0);
    @(posedge clk); #1;
    chk("h80_done_pulse", bus.done, 0);
    chk("h80_guess_hold", bus.guess, 32'h80);
    chk("h80_result_hold", bus.result, 32'h80);

    launch(8'h00); finish("h00", 8'h00, 1'b0, 8, 0, 1'b0);
    @(posedge clk); #1;
    launch(8'hFF); finish("hFF", 8'hFF, 1'b0, 8, 0, 1'b0);
    @(posedge clk); #1;
    launch(8'h5A); finish("h5A", 8'h5A, 1'b0, 7, 0, 1'b0);
    @(posedge clk); #1;

    // Trials 0x80 (gt), 0x40 (lt), 0x60 (flags killed) -> 0x60 with err.
    launch(8'h5A); finish("fault", 8'h60, 1'b1, 3, 3, 1'b0);
    @(posedge clk); #1;
    chk("fault_err_held", bus.err, 1);
    launch(8'h33);
    chk("fault_err_cleared_result", bus.result, 32'h60);
    finish("after_fault", 8'h33, 1'b0, 8, 0, 1'b0);
    @(posedge clk); #1;

    launch(8'h5A); finish("busy_start", 8'h5A, 1'b0, 7, 0, 1'b1);

    // Start in the done cycle: result held, new search running next cycle.
    launch(8'h01);
    chk("coinc_result_held", bus.result, 32'h5A);
    finish("coinc", 8'h01, 1'b0, 8, 0, 1'b0);
    @(posedge clk); #1;

    for (int h = 0; h < 256; h++) begin
      launch(8'(h));
      finish("sweep", 8'(h), 1'b0, sweep_trials(8'(h)), 0, 1'b0);
      @(posedge clk); #1;
      chk("sweep_single_done", bus.done, 0);
    end

    // Async reset during trial 4 (guess 0x80 -> 0x40 -> 0x60 -> 0x50).
    launch(8'h5A);
    repeat (3) @(posedge clk);
    #1;
    chk("mid_guess_t4", bus.guess, 32'h50);
    chk("mid_result_prev", bus.result, 32'hFF);
    #2 rst = 1'b1;
    #1;
    chk("arst_guess",  bus.guess,  0);
    chk("arst_busy",   bus.busy,   0);
    chk("arst_done",   bus.done,   0);
    chk("arst_result", bus.result, 0);
    chk("arst_err",    bus.err,    0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_arst_idle", bus.busy, 0);
    launch(8'hC3); finish("post_arst", 8'hC3, 1'b0, 8, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
